// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the serial sequence detector: FSM state
// encoding, fill-counter width and the legal range of the history length.
package seq_detector_pkg;

    localparam int W_MIN = 2;
    localparam int W_MAX = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FILL  = 2'b01,
        ST_ARMED = 2'b10
    } state_t;

    // Fill counts 0..w inclusive, so it needs one more code than w itself.
    function automatic int fill_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky flag that is set
// on the increment that reaches all-ones.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          sat
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX - 1'b1) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detector_n.sv
// W-bit serial sequence detector with runtime pattern, valid qualifier,
// overlap/non-overlap mode, saturating match counter and soft clear.
module seq_detector_n
    import seq_detector_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sig,
    input  logic [W-1:0]     pattern,
    input  logic             overlap,
    input  logic             clear,
    output logic [W-1:0]     hist,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [1:0]       state_o
);

    localparam int FW = fill_w(W);
    localparam logic [FW-1:0] FILL_ARM  = FW'(W - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(W);

    if ((W < W_MIN) || (W > W_MAX)) begin : g_bad_w
        $error("seq_detector_n: W out of range");
    end

    state_t        state;
    state_t        state_next;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_next;
    logic [W-1:0]  hist_next;
    logic          state_ok;
    logic          match_now;

    // Match is judged on the pre-shift history plus the incoming bit; fill
    // gating keeps the zero history after reset from matching a zero pattern.
    always_comb begin
        hist_next = {hist[W-2:0], in_sig};
        state_ok  = (state == ST_EMPTY) || (state == ST_FILL) || (state == ST_ARMED);
        match_now = in_valid && state_ok && (fill >= FILL_ARM) && (hist_next == pattern);

        if (match_now) begin
            fill_next = overlap ? FILL_FULL : '0;
        end else if (fill >= FILL_FULL) begin
            fill_next = FILL_FULL;
        end else begin
            fill_next = fill + 1'b1;
        end

        if (fill_next == '0) begin
            state_next = ST_EMPTY;
        end else if (fill_next >= FILL_ARM) begin
            state_next = ST_ARMED;
        end else begin
            state_next = ST_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist  <= '0;
            fill  <= '0;
            state <= ST_EMPTY;
            match <= 1'b0;
        end else if (!state_ok) begin
            fill  <= '0;
            state <= ST_EMPTY;
            match <= 1'b0;
        end else if (in_valid) begin
            hist  <= hist_next;
            fill  <= fill_next;
            state <= state_next;
            match <= match_now;
        end else begin
            match <= 1'b0;
        end
    end

    assign state_o = state;

    sat_counter #(
        .CW(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clear),
        .inc(match_now),
        .cnt(match_cnt),
        .sat(cnt_sat)
    );

endmodule

// File: doc/seq_detector_n.md
Name: seq_detector_n

Overview:
Parametrised serial sequence detector and history tracker. It generalises the fixed 2-bit history FSM to a W-bit history with a runtime-programmable pattern. It adds an input-valid qualifier, an overlap/non-overlap mode, a saturating match counter and a synchronous clear. It sits between a serial bit source and the control/status logic that consumes match events.

Parameters:
W, 4, pattern and history length in bits; legal range 2..16.
CNT_W, 8, width of the match counter; legal range 1..16.

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  qualifies in_sig; the block does nothing when low
in_sig  in  1  serial input bit
pattern  in  W  target sequence; the MSB is the oldest bit; must be stable while in_valid=1
overlap  in  1  1 = overlapping matches allowed; 0 = the bits of a match are consumed
clear  in  1  synchronous soft clear of history, fill, counter and sticky flag
hist  out  W  last W accepted bits, newest in the LSB
match  out  1  one-cycle pulse, registered
match_cnt  out  CNT_W  number of matches, saturating
cnt_sat  out  1  sticky; set when match_cnt saturates
state_o  out  2  current FSM state encoding

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values (rst=1 at posedge): hist=0, match=0, match_cnt=0, cnt_sat=0, fill=0, state=ST_EMPTY.
- Priority order: rst > clear > in_valid.
- clear has the same effect as rst on every output and on all internal state.
- FSM states, driven by the fill count (valid bits accumulated toward a match, range 0..W):
  - ST_EMPTY=2'b00: fill=0.
  - ST_FILL=2'b01: 0<fill<W-1.
  - ST_ARMED=2'b10: fill>=W-1, so the next valid bit can complete a match.
  - 2'b11 is unused. If ever entered, the next cycle goes to ST_EMPTY with fill=0.
- Accepted bit (in_valid=1, no rst/clear): hist <= {hist[W-2:0], in_sig}.
- The history always shifts, regardless of mode or match.
- Match condition, evaluated on the pre-shift state: fill>=W-1 AND {hist[W-2:0], in_sig}==pattern.
- On a match:
  - match=1 in the next cycle (latency 1 from the sampling edge).
  - match_cnt increments unless already all-ones; when it reaches all-ones, cnt_sat<=1.
  - fill <= overlap ? W : 0.
- On an accepted bit with no match: fill <= min(fill+1, W).
- in_valid=0: hist, fill, state and match_cnt hold; match=0.
- match is never asserted for two consecutive cycles unless two consecutive accepted bits both match. This is possible only with overlap=1 and a periodic pattern, e.g. all-ones.
- After reset, the zero-filled hist cannot produce a match. Fill gating requires W real accepted bits first.
- Toggling overlap applies to the next match event only; no retroactive effect.
- Changing pattern while in_valid=1 is a usage error, with no guaranteed result. The bench must not do it.
- Saturation: match_cnt stays at 2^CNT_W-1. cnt_sat stays 1 until rst or clear.
- Width rule: fill is $clog2(W+1) bits wide; comparisons are unsigned.
- Compatibility: with W=2, overlap=1 and in_valid tied high, hist equals the legacy 2-bit state sequence once two bits have been accepted.

Decomposition:
- Package seq_detector_pkg holds:
  - the state_t enum (ST_EMPTY, ST_FILL, ST_ARMED);
  - the localparam function fill_w(W) = $clog2(W+1);
  - the parameter legality limits (W_MIN=2, W_MAX=16).
- One natural sub-module: sat_counter, a parametrised saturating counter with inc, clr and sticky sat outputs. It is used for match_cnt/cnt_sat.
- History shift, fill and FSM logic stay in the top module.

Test Plan:
1. Reset: drive rst=1 for 2 cycles mid-stream, then release. Required: hist=0, match=0, match_cnt=0, cnt_sat=0, state_o=2'b00 on the first cycle after release.
2. Overlap: W=4, pattern=4'b1011, overlap=1, bits 1,0,1,1,0,1,1 with in_valid=1. Required: match pulses one cycle after the 4th and the 7th bit; match_cnt=2; final hist=4'b1011.
3. Non-overlap: same stimulus as test 2 with overlap=0. Required: match only after the 4th bit; match_cnt=1; state_o returns to 2'b00 after that match.
4. Valid gaps: the stream from test 2 with 3 in_valid=0 cycles between every bit. Required: identical match count (2); hist, match_cnt and state_o unchanged during gaps; match=0 during gaps.
5. Saturation: CNT_W=2, W=2, pattern=2'b11, overlap=1, six consecutive 1s. Required: five matches; match_cnt stops at 3; cnt_sat=1 from the third match onward; then clear=1 sets match_cnt=0 and cnt_sat=0.
6. Clear priority and fill gating: W=4, pattern=4'b0000; assert clear with in_valid=1, in_sig=0; then feed four 0s. Required: the clear-cycle bit is not accepted (hist=0, fill=0); no match after 3 zeros; match after the 4th zero.
